// File: rtl/riscv_mc_controller.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the RV32I core.
// Optional RISCV_MC_PERF_EN adds cycle_cnt / instret_cnt outputs.
//
// state  | meaning
// FETCH  | imem_req held until imem_rvalid; IR loads on the response
// DECODE | IR stable for one cycle; unsupported encodings trap
// EXEC   | ALU/branch/jump retire here; loads/stores go on to MEM
// MEM    | dmem_req held until dmem_ready, then retire
// TRAP   | sticky fault, strobes idle until rst
//
// Decoder field encodings: wb_sel 2'd1 = memory data; rf_wen/mem_wen 1 = write;
// pc_sel 0 = PC+4, 1 = branch target, 2 = ALU result.
module riscv_mc_controller #(
  parameter int WORD_LENGTH    = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  input  logic       imem_rvalid,
  output logic       ir_we,
  input  logic       inst_valid,
  input  logic [1:0] wb_sel,
  input  logic       rf_wen,
  input  logic       mem_wen,
  input  logic [1:0] pc_sel,
  input  logic       br_taken,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       pc_we,
  output logic [1:0] pc_next_sel,
  output logic       rf_we,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
`ifdef RISCV_MC_PERF_EN
  ,
  output logic [WORD_LENGTH-1:0] cycle_cnt,
  output logic [WORD_LENGTH-1:0] instret_cnt
`endif
);

  localparam logic [1:0] WB_MEM      = 2'd1;
  localparam logic       RF_WRITE    = 1'b1;
  localparam logic       MEM_WRITE   = 1'b1;
  localparam logic [1:0] PC_PLUS4    = 2'd0;
  localparam logic [1:0] PC_B_TARGET = 2'd1;
  localparam logic [1:0] PC_ALU      = 2'd2;

  // Wait timer is a down-counter reloaded on every state change; expiry at zero.
  localparam int          TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TLOAD = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_TRAP   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cause_q, cause_d;

  logic is_load, is_store;
  assign is_load  = (wb_sel == WB_MEM);
  assign is_store = (mem_wen == MEM_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      timer_q <= TLOAD;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = TLOAD;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_rvalid) begin
          state_d = S_DECODE;
        end else if (TO_EN && (timer_q == '0)) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else if (TO_EN) begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DECODE: begin
        if (!inst_valid) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_FETCH;
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_FETCH;
        end else if (TO_EN && (timer_q == '0)) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end else if (TO_EN) begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_we       = 1'b0;
    pc_next_sel = PC_PLUS4;
    rf_we       = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_rvalid;
        end
        S_EXEC: begin
          if (!(is_load || is_store)) begin
            pc_we = 1'b1;
            rf_we = (rf_wen == RF_WRITE);
            if (pc_sel == PC_ALU)
              pc_next_sel = PC_ALU;
            else if ((pc_sel == PC_B_TARGET) && br_taken)
              pc_next_sel = PC_B_TARGET;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ready) begin
            pc_we = 1'b1;
            rf_we = !is_store;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o    = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

`ifdef RISCV_MC_PERF_EN
  logic [WORD_LENGTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [WORD_LENGTH-1:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + WORD_LENGTH'(state_q != S_TRAP);
    instret_cnt_d = instret_cnt_q + WORD_LENGTH'(pc_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
